mask_encoder: RTL and testbench

MASK_ENCODER -- requirements
Module: mask_encoder

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/prio_enc32.sv | 26 ++
 rtl/mask_encoder.sv | 97 +++++++++
 tb/tb_mask_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes, state encoding and popcount helper for the register-mask encoder
//
// Contents:
//   NUM_REGS / IDX_W / CNT_W : mask width, index width, pending-count width
//   state_t                  : IDLE (nothing pending) / SCAN (indices pending)
//   popcount32()             : number of set bits in a NUM_REGS-wide mask
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // CNT_W is one bit wider than IDX_W so a full mask counts to 32 without wrapping.
    function automatic logic [CNT_W-1:0] popcount32(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc32.sv
// rtl/prio_enc32.sv - combinational lowest-set-bit priority encoder
//
// Ports:
//   i_vec : NUM_REGS-bit input vector
//   o_idx : index of the lowest set bit (0 when i_vec is zero)
//   o_any : at least one bit of i_vec is set
module prio_enc32
    import regfile_pkg::*;
(
    input  logic [NUM_REGS-1:0] i_vec,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mask_encoder.sv
// rtl/mask_encoder.sv - converts a 32-bit register mask into a stream of register indices
//
// Accepts a register mask in IDLE, then emits the index of every set bit,
// lowest first, one per idx_valid/idx_ready handshake.
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous active-low reset
//   load_valid : a mask is offered on load_mask
//   load_mask  : register mask, bit k selects register k
//   load_ready : block can accept a mask (IDLE and out of reset)
//   idx_valid  : idx holds a pending register index
//   idx        : lowest pending register index
//   idx_last   : idx is the final pending index
//   idx_ready  : consumer takes idx this cycle
//   count      : number of indices still pending (0..32)
//
// Build option:
//   REGFILE_R0_SKIP_EN : register 0 is hardwired; bit 0 of load_mask is cleared at load.
module mask_encoder
    import regfile_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [NUM_REGS-1:0] load_mask,
    output logic                load_ready,
    output logic                idx_valid,
    output logic [IDX_W-1:0]    idx,
    output logic                idx_last,
    input  logic                idx_ready,
    output logic [CNT_W-1:0]    count
);

    state_t              r_state;
    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_count;

    logic [NUM_REGS-1:0] w_mask;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_single;

`ifdef REGFILE_R0_SKIP_EN
    assign w_mask = load_mask & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
`else
    assign w_mask = load_mask;
`endif

    prio_enc32 u_prio_enc32 (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Clearing the lowest set bit leaves zero exactly when one bit remains.
    assign w_single = w_any && ((r_pending & (r_pending - {{(NUM_REGS-1){1'b0}}, 1'b1})) == '0);

    // All index-side outputs are decoded purely from registered state, so
    // they stay stable for as long as the consumer stalls.
    assign load_ready = (r_state == IDLE) && reset;
    assign idx_valid  = (r_state == SCAN) && w_any;
    assign idx        = w_idx;
    assign idx_last   = idx_valid && w_single;
    assign count      = r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_pending <= w_mask;
                        r_count   <= popcount32(w_mask);
                        // An empty mask has nothing to emit, so stay ready.
                        r_state   <= (w_mask != '0) ? SCAN : IDLE;
                    end
                end
                SCAN: begin
                    // load_valid is deliberately ignored here.
                    if (idx_ready) begin
                        r_pending <= r_pending & (r_pending - {{(NUM_REGS-1){1'b0}}, 1'b1});
                        r_count   <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (w_single) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_encoder.sv
// tb/tb_mask_encoder.sv - scoreboard testbench for mask_encoder
module tb_mask_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_mask = '0;
    logic        load_ready;
    logic        idx_valid;
    logic [4:0]  idx;
    logic        idx_last;
    logic        idx_ready = 1'b0;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
        logic [5:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    mask_encoder dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .idx_valid  (idx_valid),
        .idx        (idx),
        .idx_last   (idx_last),
        .idx_ready  (idx_ready),
        .count      (count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected index stream for a mask: set bits lowest first, count counting down.
    task automatic push_exp(input logic [31:0] mask, output int n);
        logic [31:0] m;
        int rem;
        m = mask;
`ifdef REGFILE_R0_SKIP_EN
        m[0] = 1'b0;
`endif
        n = 0;
        for (int k = 0; k < 32; k++) n += int'(m[k]);
        rem = n;
        for (int k = 0; k < 32; k++) begin
            if (m[k]) begin
                q.push_back('{idx: 5'(k), last: (rem == 1), cnt: 6'(rem)});
                rem--;
            end
        end
    endtask

    // Monitor: every handshake pops one expected entry.
    always @(negedge clock) begin
        if (reset && idx_valid && idx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_idx actual=%0d required=none", idx);
            end else begin
                mon_e = q.pop_front();
                check("idx", 32'(idx), 32'(mon_e.idx));
                check("idx_last", 32'(idx_last), 32'(mon_e.last));
                check("count", 32'(count), 32'(mon_e.cnt));
            end
        end
    end

    // Ends on the negedge after the accepting edge.
    task automatic do_load(input logic [31:0] mask, output int n);
        int t;
        t = 0;
        @(negedge clock);
        while (!load_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL load_ready_timeout actual=0 required=1");
        end
        load_valid = 1'b1;
        load_mask  = mask;
        push_exp(mask, n);
        @(posedge clock);
        #1 load_valid = 1'b0;
        @(negedge clock);
        check("latency_valid", 32'(idx_valid), 32'(n != 0));
    endtask

    // Counts negedges (starting at 1) until load_ready is seen again.
    task automatic drain(output int cyc);
        cyc = 1;
        while (!load_ready && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=<200", cyc);
        end
        check("queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, c;
        logic [31:0] zmasks [2];
        zmasks[0] = 32'h0000_0000;
        zmasks[1] = 32'h0000_0001;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_idx_last", 32'(idx_last), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        idx_ready = 1'b1;
        @(negedge clock);
        check("idle_load_ready", 32'(load_ready), 32'd1);

        // 0x80000005 at full rate
        do_load(32'h8000_0005, n);
        drain(c);
        check("tput_3", 32'(c), 32'(n + 1));

        // 0x10 with a 5-cycle stall
        @(posedge clock);
        #1 idx_ready = 1'b0;
        do_load(32'h0000_0010, n);
        for (int i = 0; i < 5; i++) begin
            check("stall_idx", 32'(idx), 32'd4);
            check("stall_last", 32'(idx_last), 32'd1);
            check("stall_count", 32'(count), 32'd1);
            check("stall_valid", 32'(idx_valid), 32'd1);
            @(posedge clock);
            #1;
            @(negedge clock);
        end
        @(posedge clock);
        #1 idx_ready = 1'b1;
        drain(c);

        // Full mask
        do_load(32'hFFFF_FFFF, n);
        drain(c);
        check("tput_full", 32'(c), 32'(n + 1));

        // Empty masks (0x1 is empty only with register 0 hardwired)
        foreach (zmasks[j]) begin
            do_load(zmasks[j], n);
            if (n == 0) begin
                repeat (3) begin
                    check("empty_valid", 32'(idx_valid), 32'd0);
                    check("empty_ready", 32'(load_ready), 32'd1);
                    @(negedge clock);
                end
            end
            drain(c);
        end

        // Reset mid-scan of 0xF000 after the second handshake
        do_load(32'h0000_F000, n);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        idx_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("midrst_valid", 32'(idx_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_load_ready", 32'(load_ready), 32'd0);
        check("midrst_pending", 32'(q.size()), 32'd2);
        q.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        idx_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("postrst_valid", 32'(idx_valid), 32'd0);
            check("postrst_ready", 32'(load_ready), 32'd1);
        end

        // load_valid held with 0x3 while scanning 0x100
        @(posedge clock);
        #1 idx_ready = 1'b0;
        @(negedge clock);
        load_valid = 1'b1;
        load_mask  = 32'h0000_0100;
        push_exp(32'h0000_0100, n);
        @(posedge clock);
        #1 load_mask = 32'h0000_0003;
        push_exp(32'h0000_0003, n);
        repeat (2) begin
            @(negedge clock);
            check("noovr_idx", 32'(idx), 32'd8);
            check("noovr_count", 32'(count), 32'd1);
        end
        @(posedge clock);
        #1 idx_ready = 1'b1;
        c = 0;
        @(negedge clock);
        while (!load_ready && c < 100) begin
            @(negedge clock);
            c++;
        end
        check("hold_accept_seen", 32'(load_ready), 32'd1);
        @(posedge clock);
        #1 load_valid = 1'b0;
        @(negedge clock);
        drain(c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
